// File: rtl/vlsu_cam_alloc_ctrl.sv
// rtl/vlsu_cam_alloc_ctrl.sv - FIFO-order entry allocator and pipelined multi-port lookup front end for vlsu_cam_top
// Define CAM_FLUSH_EN to add flush_i and the FLUSH state; the default build has neither.
module vlsu_cam_alloc_ctrl #(
  parameter int WIDTH   = 50,
  parameter int DEPTH   = 32,
  parameter int READ    = 3,
  parameter int ADDRESS = $clog2(DEPTH),
  parameter int LKP_LAT = 1
) (
  input  logic                      clk,
  input  logic                      arst_n,
`ifdef CAM_FLUSH_EN
  input  logic                      flush_i,
`endif
  input  logic                      alloc_valid_i,
  input  logic [WIDTH-1:0]          alloc_data_i,
  output logic                      alloc_ready_o,
  output logic [ADDRESS-1:0]        alloc_idx_o,
  input  logic                      retire_i,
  input  logic [READ-1:0]           lkp_valid_i,
  input  logic [READ*WIDTH-1:0]     lkp_data_i,
  output logic                      lkp_ready_o,
  output logic [READ-1:0]           lkp_resp_o,
  output logic [READ-1:0]           lkp_hit_o,
  output logic [READ*ADDRESS-1:0]   lkp_idx_o,
  output logic                      cam_write_o,
  output logic [ADDRESS-1:0]        cam_write_addr_o,
  output logic [WIDTH-1:0]          cam_write_data_o,
  output logic [ADDRESS-1:0]        cam_head_o,
  output logic [READ*DEPTH-1:0]     cam_enable_o,
  output logic [READ-1:0]           cam_read_o,
  output logic [READ*WIDTH-1:0]     cam_read_data_o,
  input  logic [READ-1:0]           cam_match_i,
  input  logic [READ*ADDRESS-1:0]   cam_match_addr_i,
  output logic [ADDRESS:0]          count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  localparam logic [ADDRESS-1:0] ADDR_ONE = ADDRESS'(1);
  localparam logic [ADDRESS:0]   CNT_ONE  = (ADDRESS+1)'(1);
  localparam logic [ADDRESS:0]   CNT_FULL = (ADDRESS+1)'(DEPTH);

  state_e                    state_q, state_d;
  logic [ADDRESS-1:0]        head_q, head_d;
  logic [ADDRESS-1:0]        tail_q, tail_d;
  logic [ADDRESS:0]          count_q, count_d;
  logic [DEPTH-1:0]          valid_q, valid_d;
  logic                      full_q, full_d;
  logic                      empty_q, empty_d;
  logic                      alloc_ready_q, alloc_ready_d;
  logic                      lkp_ready_q, lkp_ready_d;
  logic                      write_q, write_d;
  logic [ADDRESS-1:0]        write_addr_q, write_addr_d;
  logic [WIDTH-1:0]          write_data_q, write_data_d;
  logic [READ-1:0]           read_q, read_d;
  logic [READ*WIDTH-1:0]     read_data_q, read_data_d;
  logic [LKP_LAT-1:0][READ-1:0] pipe_q;

  logic                      alloc_fire;
  logic                      retire_fire;
  logic [READ-1:0]           lkp_fire;
`ifdef CAM_FLUSH_EN
  logic                      pipe_busy;
`endif

  always_comb begin
    alloc_fire   = alloc_valid_i & alloc_ready_q;
    retire_fire  = retire_i & ~empty_q & (state_q == RUN);
    lkp_fire     = lkp_valid_i & {READ{lkp_ready_q}};

    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    valid_d      = valid_q;
    write_d      = alloc_fire;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    read_d       = lkp_fire;
    read_data_d  = read_data_q;

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + ADDR_ONE;
      write_addr_d    = tail_q;
      write_data_d    = alloc_data_i;
    end
    // head never equals tail here: that would mean empty (no retire) or full (no alloc)
    if (retire_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + ADDR_ONE;
    end

    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    for (int p = 0; p < READ; p++) begin
      if (lkp_fire[p]) read_data_d[p*WIDTH +: WIDTH] = lkp_data_i[p*WIDTH +: WIDTH];
    end

`ifdef CAM_FLUSH_EN
    pipe_busy = (|read_q) | (|pipe_q);
    case (state_q)
      RUN: begin
        if (flush_i) state_d = FLUSH;
      end
      FLUSH: begin
        if (!pipe_busy) begin
          state_d = RUN;
          valid_d = '0;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
`endif

    full_d        = (count_d == CNT_FULL);
    empty_d       = (count_d == '0);
    alloc_ready_d = (state_d == RUN) & ~full_d;
    lkp_ready_d   = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= RUN;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      valid_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      alloc_ready_q <= 1'b1;
      lkp_ready_q   <= 1'b1;
      write_q       <= 1'b0;
      write_addr_q  <= '0;
      write_data_q  <= '0;
      read_q        <= '0;
      read_data_q   <= '0;
      pipe_q        <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      alloc_ready_q <= alloc_ready_d;
      lkp_ready_q   <= lkp_ready_d;
      write_q       <= write_d;
      write_addr_q  <= write_addr_d;
      write_data_q  <= write_data_d;
      read_q        <= read_d;
      read_data_q   <= read_data_d;
      // tag pipe tracks which ports have a CAM result due LKP_LAT cycles after cam_read_o
      pipe_q[0]     <= read_q;
      for (int i = 1; i < LKP_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_comb begin
    lkp_resp_o = pipe_q[LKP_LAT-1];
    lkp_hit_o  = '0;
    lkp_idx_o  = '0;
    for (int p = 0; p < READ; p++) begin
      lkp_hit_o[p] = lkp_resp_o[p] & cam_match_i[p];
      if (lkp_hit_o[p]) lkp_idx_o[p*ADDRESS +: ADDRESS] = cam_match_addr_i[p*ADDRESS +: ADDRESS];
    end
  end

  assign alloc_ready_o    = alloc_ready_q;
  assign alloc_idx_o      = tail_q;
  assign lkp_ready_o      = lkp_ready_q;
  assign cam_write_o      = write_q;
  assign cam_write_addr_o = write_addr_q;
  assign cam_write_data_o = write_data_q;
  assign cam_head_o       = head_q;
  assign cam_enable_o     = {READ{valid_q}};
  assign cam_read_o       = read_q;
  assign cam_read_data_o  = read_data_q;
  assign count_o          = count_q;
  assign full_o           = full_q;
  assign empty_o          = empty_q;

endmodule

// File: tb/tb_vlsu_cam_alloc_ctrl.sv
// tb/tb_vlsu_cam_alloc_ctrl.sv - directed bench for vlsu_cam_alloc_ctrl with a behavioural CAM (LKP_LAT=1)
module tb_vlsu_cam_alloc_ctrl;
  localparam int WIDTH = 50, DEPTH = 32, READ = 3, ADDRESS = 5;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
`ifdef CAM_FLUSH_EN
  logic flush_i = 1'b0;
`endif
  logic                    alloc_valid_i = 1'b0;
  logic [WIDTH-1:0]        alloc_data_i = '0;
  logic                    alloc_ready_o;
  logic [ADDRESS-1:0]      alloc_idx_o;
  logic                    retire_i = 1'b0;
  logic [READ-1:0]         lkp_valid_i = '0;
  logic [READ*WIDTH-1:0]   lkp_data_i = '0;
  logic                    lkp_ready_o;
  logic [READ-1:0]         lkp_resp_o, lkp_hit_o;
  logic [READ*ADDRESS-1:0] lkp_idx_o;
  logic                    cam_write_o;
  logic [ADDRESS-1:0]      cam_write_addr_o, cam_head_o;
  logic [WIDTH-1:0]        cam_write_data_o;
  logic [READ*DEPTH-1:0]   cam_enable_o;
  logic [READ-1:0]         cam_read_o;
  logic [READ*WIDTH-1:0]   cam_read_data_o;
  logic [READ-1:0]         cam_match_i = '0;
  logic [READ*ADDRESS-1:0] cam_match_addr_i = '0;
  logic [ADDRESS:0]        count_o;
  logic                    full_o, empty_o;

  int checks = 0;
  int errors = 0;

  vlsu_cam_alloc_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READ(READ), .ADDRESS(ADDRESS), .LKP_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n),
`ifdef CAM_FLUSH_EN
    .flush_i(flush_i),
`endif
    .alloc_valid_i(alloc_valid_i), .alloc_data_i(alloc_data_i), .alloc_ready_o(alloc_ready_o),
    .alloc_idx_o(alloc_idx_o), .retire_i(retire_i), .lkp_valid_i(lkp_valid_i), .lkp_data_i(lkp_data_i),
    .lkp_ready_o(lkp_ready_o), .lkp_resp_o(lkp_resp_o), .lkp_hit_o(lkp_hit_o), .lkp_idx_o(lkp_idx_o),
    .cam_write_o(cam_write_o), .cam_write_addr_o(cam_write_addr_o), .cam_write_data_o(cam_write_data_o),
    .cam_head_o(cam_head_o), .cam_enable_o(cam_enable_o), .cam_read_o(cam_read_o),
    .cam_read_data_o(cam_read_data_o), .cam_match_i(cam_match_i), .cam_match_addr_i(cam_match_addr_i),
    .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: one-cycle search using the enable mask and stored data seen during the read cycle
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDRESS:0] srch;

  function automatic logic [ADDRESS:0] search(input logic [WIDTH-1:0] key, input logic [DEPTH-1:0] en,
                                              input logic [ADDRESS-1:0] hd);
    logic [ADDRESS-1:0] ix;
    for (int k = 0; k < DEPTH; k++) begin
      ix = hd + ADDRESS'(k);
      if (en[ix] && mem[ix] == key) return {1'b1, ix};
    end
    return '0;
  endfunction

  always @(posedge clk) begin
    for (int p = 0; p < READ; p++) begin
      srch = search(cam_read_data_o[p*WIDTH +: WIDTH], cam_enable_o[p*DEPTH +: DEPTH], cam_head_o);
      cam_match_i[p] <= cam_read_o[p] & srch[ADDRESS];
      cam_match_addr_i[p*ADDRESS +: ADDRESS] <= srch[ADDRESS-1:0];
    end
    if (cam_write_o) mem[cam_write_addr_o] <= cam_write_data_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #12;
    chk("rst_alloc_ready", alloc_ready_o, 1);
    chk("rst_lkp_ready", lkp_ready_o, 1);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_enable", cam_enable_o[63:0], 0);
    chk("rst_write", cam_write_o, 0);
    chk("rst_resp", lkp_resp_o, 0);
    chk("rst_idx", alloc_idx_o, 0);
    arst_n = 1'b1;
    tick();

    // reset asserted while a lookup is in flight
    lkp_valid_i = 3'b001;
    lkp_data_i  = {WIDTH'(0), WIDTH'(0), WIDTH'(7)};
    tick();
    chk("t1_read", cam_read_o, 3'b001);
    arst_n = 1'b0;
    lkp_valid_i = '0;
    #1;
    chk("t1_read_rst", cam_read_o, 0);
    chk("t1_ready_rst", alloc_ready_o, 1);
    arst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_no_resp", lkp_resp_o, 0);
    end

    // fill all entries
    for (int i = 0; i < 32; i++) begin
      alloc_valid_i = 1'b1;
      alloc_data_i  = WIDTH'(i + 1);
      chk("t2_idx", alloc_idx_o, i);
      chk("t2_ready", alloc_ready_o, 1);
      tick();
      chk("t2_write", cam_write_o, 1);
      chk("t2_waddr", cam_write_addr_o, i);
      chk("t2_wdata", cam_write_data_o, i + 1);
    end
    alloc_data_i = WIDTH'(33);
    chk("t2_full", full_o, 1);
    chk("t2_count", count_o, 32);
    chk("t2_not_ready", alloc_ready_o, 0);
    tick();
    chk("t2_33_rejected", cam_write_o, 0);
    chk("t2_count_hold", count_o, 32);
    alloc_valid_i = 1'b0;

    // three-port lookup
    lkp_valid_i = 3'b111;
    lkp_data_i  = {WIDTH'(99), WIDTH'(32), WIDTH'(5)};
    tick();
    chk("t3_read", cam_read_o, 3'b111);
    chk("t3_enable_lo", cam_enable_o[63:0], 64'hffff_ffff_ffff_ffff);
    chk("t3_enable_hi", cam_enable_o[95:64], 32'hffff_ffff);
    lkp_valid_i = '0;
    tick();
    chk("t3_resp", lkp_resp_o, 3'b111);
    chk("t3_hit", lkp_hit_o, 3'b011);
    chk("t3_idx", lkp_idx_o, {5'd0, 5'd31, 5'd4});
    tick();
    chk("t3_resp_pulse", lkp_resp_o, 0);

    // retire 3, wrap-around allocations
    retire_i = 1'b1;
    repeat (3) tick();
    retire_i = 1'b0;
    chk("t4_head", cam_head_o, 3);
    chk("t4_count", count_o, 29);
    chk("t4_enable", cam_enable_o[31:0], 32'hffff_fff8);
    for (int j = 0; j < 3; j++) begin
      alloc_valid_i = 1'b1;
      alloc_data_i  = WIDTH'(40 + j);
      chk("t4_idx", alloc_idx_o, j);
      tick();
      chk("t4_waddr", cam_write_addr_o, j);
    end
    alloc_valid_i = 1'b0;
    chk("t4_full", full_o, 1);
    chk("t4_head_hold", cam_head_o, 3);
    lkp_valid_i = 3'b111;
    lkp_data_i  = {WIDTH'(42), WIDTH'(2), WIDTH'(41)};
    tick();
    lkp_valid_i = '0;
    tick();
    chk("t4_resp", lkp_resp_o, 3'b111);
    chk("t4_hit", lkp_hit_o, 3'b101);
    chk("t4_idx", lkp_idx_o, {5'd2, 5'd0, 5'd1});

    // entry retired during the read cycle still hits
    lkp_valid_i = 3'b001;
    lkp_data_i  = {WIDTH'(0), WIDTH'(0), WIDTH'(4)};
    tick();
    lkp_valid_i = '0;
    retire_i = 1'b1;
    tick();
    retire_i = 1'b0;
    chk("snap_retire_hit", lkp_hit_o, 3'b001);
    chk("snap_retire_idx", lkp_idx_o, {5'd0, 5'd0, 5'd3});
    chk("snap_head", cam_head_o, 4);
    chk("snap_count", count_o, 31);

    // entry written during the read cycle does not hit
    alloc_valid_i = 1'b1;
    alloc_data_i  = WIDTH'(50);
    lkp_valid_i   = 3'b010;
    lkp_data_i    = {WIDTH'(0), WIDTH'(50), WIDTH'(0)};
    tick();
    alloc_valid_i = 1'b0;
    lkp_valid_i   = '0;
    chk("snap_waddr", cam_write_addr_o, 3);
    chk("snap_read", cam_read_o, 3'b010);
    tick();
    chk("snap_write_resp", lkp_resp_o, 3'b010);
    chk("snap_write_miss", lkp_hit_o, 3'b000);
    chk("snap_write_idx", lkp_idx_o, 0);
    chk("snap_count_full", count_o, 32);

    // alloc+retire while full, then with count 31
    alloc_valid_i = 1'b1;
    alloc_data_i  = WIDTH'(60);
    retire_i      = 1'b1;
    chk("t5_ready_full", alloc_ready_o, 0);
    tick();
    chk("t5_rejected", cam_write_o, 0);
    chk("t5_count31", count_o, 31);
    chk("t5_head5", cam_head_o, 5);
    chk("t5_ready_again", alloc_ready_o, 1);
    tick();
    alloc_valid_i = 1'b0;
    retire_i      = 1'b0;
    chk("t5_both_write", cam_write_o, 1);
    chk("t5_both_waddr", cam_write_addr_o, 4);
    chk("t5_both_wdata", cam_write_data_o, 60);
    chk("t5_both_count", count_o, 31);
    chk("t5_both_head", cam_head_o, 6);

    // drain, then retire on empty is ignored
    retire_i = 1'b1;
    repeat (31) tick();
    chk("drain_empty", empty_o, 1);
    chk("drain_count", count_o, 0);
    chk("drain_head", cam_head_o, 5);
    tick();
    retire_i = 1'b0;
    chk("empty_retire_count", count_o, 0);
    chk("empty_retire_head", cam_head_o, 5);
    chk("empty_enable", cam_enable_o[31:0], 0);

`ifdef CAM_FLUSH_EN
    for (int j = 0; j < 2; j++) begin
      alloc_valid_i = 1'b1;
      alloc_data_i  = WIDTH'(70 + j);
      tick();
    end
    alloc_valid_i = 1'b0;
    flush_i     = 1'b1;
    lkp_valid_i = 3'b001;
    lkp_data_i  = {WIDTH'(0), WIDTH'(0), WIDTH'(70)};
    tick();
    flush_i     = 1'b0;
    lkp_valid_i = '0;
    chk("t6_alloc_blocked", alloc_ready_o, 0);
    chk("t6_lkp_blocked", lkp_ready_o, 0);
    tick();
    chk("t6_resp", lkp_resp_o, 3'b001);
    chk("t6_hit", lkp_hit_o, 3'b001);
    chk("t6_idx", lkp_idx_o, 5);
    for (int w = 0; w < 6 && !empty_o; w++) tick();
    chk("t6_empty", empty_o, 1);
    chk("t6_count", count_o, 0);
    chk("t6_enable", cam_enable_o[31:0], 0);
    chk("t6_alloc_ready", alloc_ready_o, 1);
    chk("t6_next_idx", alloc_idx_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
